// File: rtl/mini_alu_pkg.sv
// Shared opcodes, instruction layout, VGA timing defaults and the fixed demo program.
package mini_alu_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_STO = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_BLE = 3'd4;
  localparam logic [2:0] OP_VWR = 3'd5;
  localparam logic [2:0] OP_HLT = 3'd6;

  // 16-bit word: op[15:13] fa[12:10] fb[9:7] fc[6:4]; imm[7:0] (STO), tgt[3:0] (BLE)
  localparam int OP_LSB  = 13;
  localparam int FA_LSB  = 10;
  localparam int FB_LSB  = 7;
  localparam int FC_LSB  = 4;
  localparam int IMM_LSB = 0;
  localparam int TGT_LSB = 0;

  localparam int PROG_LEN = 16;

  localparam int VGA_H_VIS  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_V_VIS  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;

  function automatic logic [15:0] enc_sto(input logic [2:0] rd, input logic [7:0] imm);
    return {OP_STO, rd, 2'b00, imm};
  endfunction

  function automatic logic [15:0] enc_rrr(input logic [2:0] op, input logic [2:0] fa,
                                          input logic [2:0] fb, input logic [2:0] fc);
    return {op, fa, fb, fc, 4'b0000};
  endfunction

  function automatic logic [15:0] enc_ble(input logic [3:0] tgt, input logic [2:0] ra,
                                          input logic [2:0] rb);
    return {OP_BLE, 3'b000, ra, rb, tgt};
  endfunction

  // VWR keeps the data register in fa so fb/fc line up with the column/row operands.
  function automatic logic [15:0] rom_word(input logic [3:0] addr);
    logic [15:0] w;
    w = {OP_HLT, 13'd0};
    case (addr)
      4'd0:  w = enc_sto(3'd1, 8'd0);
      4'd1:  w = enc_sto(3'd5, 8'd1);
      4'd2:  w = enc_sto(3'd6, 8'd19);
      4'd3:  w = enc_sto(3'd7, 8'd14);
      4'd4:  w = enc_sto(3'd2, 8'd0);
      4'd5:  w = enc_rrr(OP_ADD, 3'd3, 3'd1, 3'd2);
      4'd6:  w = enc_rrr(OP_VWR, 3'd3, 3'd2, 3'd1);
      4'd7:  w = enc_rrr(OP_ADD, 3'd2, 3'd2, 3'd5);
      4'd8:  w = enc_ble(4'd5, 3'd2, 3'd6);
      4'd9:  w = enc_rrr(OP_ADD, 3'd1, 3'd1, 3'd5);
      4'd10: w = enc_ble(4'd4, 3'd1, 3'd7);
      default: w = {OP_HLT, 13'd0};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mini_alu_vga_timing.sv
// Free-running VGA raster counters with combinational sync, visible and cell-address decode.
module vga_timing #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] cell_row,
  output logic [4:0] cell_col,
  output logic       hs,
  output logic       vs,
  output logic       visible
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  logic [9:0] hcnt_reg;
  logic [9:0] vcnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_reg <= '0;
      vcnt_reg <= '0;
    end else if (hcnt_reg == 10'(H_TOTAL - 1)) begin
      hcnt_reg <= '0;
      vcnt_reg <= (vcnt_reg == 10'(V_TOTAL - 1)) ? 10'd0 : vcnt_reg + 10'd1;
    end else begin
      hcnt_reg <= hcnt_reg + 10'd1;
    end
  end

  assign hs = !((hcnt_reg >= 10'(H_VIS + H_FP)) && (hcnt_reg < 10'(H_VIS + H_FP + H_SYNC)));
  assign vs = !((vcnt_reg >= 10'(V_VIS + V_FP)) && (vcnt_reg < 10'(V_VIS + V_FP + V_SYNC)));
  assign visible = (hcnt_reg < 10'(H_VIS)) && (vcnt_reg < 10'(V_VIS));

  // 32x32-pixel cells: drop the five low bits of each counter.
  assign cell_row = vcnt_reg[8:5];
  assign cell_col = hcnt_reg[9:5];

endmodule

// File: rtl/mini_alu.sv
// Demo core: a fixed-program ALU CPU paints a 20x15 colour grid into video RAM that is
// scanned out on 640x480@60 VGA; the LCD port is tied off.
module mini_alu
  import mini_alu_pkg::*;
#(
  parameter int H_VIS  = VGA_H_VIS,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_VIS  = VGA_V_VIS,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP
) (
  input  logic       Clock,
  input  logic       Reset,
  output logic [3:0] SF_D,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       No_se,
  output logic       VGA_RED,
  output logic       VGA_GREEN,
  output logic       VGA_BLUE,
  output logic       VGA_HS,
  output logic       VGA_VS
);

  logic [15:0] rom [PROG_LEN];

  genvar gi;
  generate
    for (gi = 0; gi < PROG_LEN; gi++) begin : g_rom
      assign rom[gi] = rom_word(4'(gi));
    end
  endgenerate

  logic [3:0]  pc_reg, pc_next;
  logic        halt_reg, halt_next;
  logic [7:0]  regs [8];
  logic [15:0] instr;
  logic [2:0]  op, fa, fb, fc;
  logic [7:0]  imm, src1, src2;
  logic [3:0]  tgt;
  logic        reg_we, vram_we;
  logic [7:0]  reg_wdata;

  assign instr = rom[pc_reg];
  assign op    = instr[OP_LSB +: 3];
  assign fa    = instr[FA_LSB +: 3];
  assign fb    = instr[FB_LSB +: 3];
  assign fc    = instr[FC_LSB +: 3];
  assign imm   = instr[IMM_LSB +: 8];
  assign tgt   = instr[TGT_LSB +: 4];
  assign src1  = regs[fb];
  assign src2  = regs[fc];

  always_comb begin
    pc_next   = pc_reg;
    halt_next = halt_reg;
    reg_we    = 1'b0;
    reg_wdata = '0;
    vram_we   = 1'b0;
    if (!halt_reg) begin
      pc_next = pc_reg + 4'd1;
      case (op)
        OP_STO: begin reg_we = 1'b1; reg_wdata = imm;         end
        OP_ADD: begin reg_we = 1'b1; reg_wdata = src1 + src2; end
        OP_SUB: begin reg_we = 1'b1; reg_wdata = src1 - src2; end
        OP_BLE: if (src1 <= src2) pc_next = tgt;
        OP_VWR: vram_we = 1'b1;
        OP_HLT: begin pc_next = pc_reg; halt_next = 1'b1; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc_reg   <= '0;
      halt_reg <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      pc_reg   <= pc_next;
      halt_reg <= halt_next;
      if (reg_we) regs[fa] <= reg_wdata;
    end
  end

  logic [3:0] cell_row;
  logic [4:0] cell_col;
  logic       hs, vs, visible;

  vga_timing #(
    .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
    .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
  ) u_timing (
    .clk      (Clock),
    .rst_n    (Reset),
    .cell_row (cell_row),
    .cell_col (cell_col),
    .hs       (hs),
    .vs       (vs),
    .visible  (visible)
  );

  // Video RAM keeps its contents across reset; a same-address read sees the old word.
  logic [2:0] vram [512];
  logic [2:0] pix_reg;

  always_ff @(posedge Clock) begin
    if (vram_we) vram[{src2[3:0], src1[4:0]}] <= regs[fa][2:0];
    pix_reg <= vram[{cell_row, cell_col}];
  end

  logic hs_reg, vs_reg, vis_reg;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      hs_reg  <= 1'b1;
      vs_reg  <= 1'b1;
      vis_reg <= 1'b0;
    end else begin
      hs_reg  <= hs;
      vs_reg  <= vs;
      vis_reg <= visible;
    end
  end

  assign VGA_HS    = hs_reg;
  assign VGA_VS    = vs_reg;
  assign VGA_RED   = pix_reg[2] & vis_reg;
  assign VGA_GREEN = pix_reg[1] & vis_reg;
  assign VGA_BLUE  = pix_reg[0] & vis_reg;
  assign No_se     = halt_reg;

  assign SF_D   = 4'h0;
  assign LCD_E  = 1'b0;
  assign LCD_RS = 1'b0;
  assign LCD_RW = 1'b0;

endmodule

// File: tb/tb_mini_alu.sv
// Bench for mini_alu: a timing/colour model indexed by clocks since reset release.
// Vertical timing is shortened so two frames fit in a short run.
module tb_mini_alu;

  localparam int H_VIS = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_VIS = 33, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOTAL * V_TOTAL;
  localparam int HALT_CLK = 1250;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] SF_D;
  logic       LCD_E, LCD_RS, LCD_RW, No_se;
  logic       VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HS, VGA_VS;

  mini_alu #(
    .H_VIS (H_VIS), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_VIS (V_VIS), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .SF_D      (SF_D),
    .LCD_E     (LCD_E),
    .LCD_RS    (LCD_RS),
    .LCD_RW    (LCD_RW),
    .No_se     (No_se),
    .VGA_RED   (VGA_RED),
    .VGA_GREEN (VGA_GREEN),
    .VGA_BLUE  (VGA_BLUE),
    .VGA_HS    (VGA_HS),
    .VGA_VS    (VGA_VS)
  );

  always #20 Clock = ~Clock;

  int t = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic       e_hs, e_vs, e_nose;
  logic [2:0] e_rgb;
  logic [2:0] px_64_32 = 3'bxxx, px_0_0 = 3'bxxx, px_639_32 = 3'bxxx, px_640_32 = 3'bxxx;

  // Expected outputs after k rising edges with reset high (k=0: still in reset state).
  function automatic void model(input int k, output logic hs, output logic vs,
                                output logic [2:0] rgb, output logic nose);
    int n, h, v;
    hs = 1'b1; vs = 1'b1; rgb = 3'b000; nose = 1'b0;
    if (k > 0) begin
      n = k - 1;
      h = n % H_TOTAL;
      v = (n / H_TOTAL) % V_TOTAL;
      hs = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
      vs = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
      if (h < H_VIS && v < V_VIS) rgb = 3'((h / 32 + v / 32) % 8);
      nose = (k >= HALT_CLK);
    end
  endfunction

  task automatic tick();
    @(posedge Clock);
    if (Reset) t++;
    #1;
  endtask

  task automatic test_reset();
    #5 Reset = 1'b0;
    t = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_checks++;
      if ({VGA_HS, VGA_VS, VGA_RED, VGA_GREEN, VGA_BLUE, No_se, SF_D, LCD_E, LCD_RS, LCD_RW}
          !== {1'b1, 1'b1, 3'b000, 1'b0, 4'h0, 3'b000}) begin
        n_fail++;
        $display("FAIL reset cycle %0d got hs,vs,rgb,nose,sfd,e,rs,rw=%b expected 1100000000000",
                 i, {VGA_HS, VGA_VS, VGA_RED, VGA_GREEN, VGA_BLUE, No_se, SF_D, LCD_E, LCD_RS, LCD_RW});
      end
    end
  endtask

  task automatic test_hsync();
    logic prev;
    int fall1, rise1, fall2;
    fall1 = -1; rise1 = -1; fall2 = -1;
    Reset = 1'b1;
    t = 0;
    prev = VGA_HS;
    for (int i = 0; i < 2400; i++) begin
      tick();
      model(t, e_hs, e_vs, e_rgb, e_nose);
      n_checks++;
      if (VGA_HS !== e_hs) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL hsync t=%0d got %b expected %b", t, VGA_HS, e_hs);
      end
      if (prev === 1'b1 && VGA_HS === 1'b0) begin
        if (fall1 < 0) fall1 = t;
        else if (fall2 < 0) fall2 = t;
      end
      if (prev === 1'b0 && VGA_HS === 1'b1 && rise1 < 0) rise1 = t;
      prev = VGA_HS;
    end
    n_checks++;
    if (fall1 != 657) begin
      n_fail++; $display("FAIL hs_first_fall got %0d expected 657", fall1);
    end
    n_checks++;
    if (rise1 - fall1 != 96) begin
      n_fail++; $display("FAIL hs_low_width got %0d expected 96", rise1 - fall1);
    end
    n_checks++;
    if (fall2 - fall1 != 800) begin
      n_fail++; $display("FAIL hs_period got %0d expected 800", fall2 - fall1);
    end
  endtask

  task automatic test_halt();
    Reset = 1'b0;
    t = 0;
    for (int i = 0; i < 3; i++) tick();
    Reset = 1'b1;
    for (int i = 0; i < 1300; i++) begin
      tick();
      n_checks++;
      if (No_se !== 1'(t >= HALT_CLK)) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL no_se t=%0d got %b expected %b", t, No_se, t >= HALT_CLK);
      end
    end
  endtask

  task automatic test_frame();
    logic prev;
    int vf1, vr1, vf2, stop;
    vf1 = -1; vr1 = -1; vf2 = -1;
    stop = FRAME + (V_VIS + V_FP) * H_TOTAL + 10;
    prev = VGA_VS;
    for (int i = 0; i < 90000 && t < stop; i++) begin
      tick();
      model(t, e_hs, e_vs, e_rgb, e_nose);
      n_checks++;
      if ({VGA_HS, VGA_VS, VGA_RED, VGA_GREEN, VGA_BLUE, No_se} !== {e_hs, e_vs, e_rgb, e_nose}) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL frame t=%0d hs,vs,rgb,no_se got %b expected %b", t,
                   {VGA_HS, VGA_VS, VGA_RED, VGA_GREEN, VGA_BLUE, No_se}, {e_hs, e_vs, e_rgb, e_nose});
      end
      if (prev === 1'b1 && VGA_VS === 1'b0) begin
        if (vf1 < 0) vf1 = t;
        else if (vf2 < 0) vf2 = t;
      end
      if (prev === 1'b0 && VGA_VS === 1'b1 && vr1 < 0) vr1 = t;
      prev = VGA_VS;
      if (t == 32 * H_TOTAL + 64 + 1)  px_64_32  = {VGA_RED, VGA_GREEN, VGA_BLUE};
      if (t == 32 * H_TOTAL + 639 + 1) px_639_32 = {VGA_RED, VGA_GREEN, VGA_BLUE};
      if (t == 32 * H_TOTAL + 640 + 1) px_640_32 = {VGA_RED, VGA_GREEN, VGA_BLUE};
      if (t == FRAME + 1)              px_0_0    = {VGA_RED, VGA_GREEN, VGA_BLUE};
    end
    n_checks++;
    if (vf1 != (V_VIS + V_FP) * H_TOTAL + 1) begin
      n_fail++; $display("FAIL vs_first_fall got %0d expected %0d", vf1, (V_VIS + V_FP) * H_TOTAL + 1);
    end
    n_checks++;
    if (vr1 - vf1 != 1600) begin
      n_fail++; $display("FAIL vs_low_width got %0d expected 1600", vr1 - vf1);
    end
    n_checks++;
    if (vf2 - vf1 != FRAME) begin
      n_fail++; $display("FAIL vs_period got %0d expected %0d", vf2 - vf1, FRAME);
    end
  endtask

  task automatic test_pixels();
    n_checks++;
    if (px_64_32 !== 3'b011) begin
      n_fail++; $display("FAIL pixel_64_32 got %b expected 011", px_64_32);
    end
    n_checks++;
    if (px_0_0 !== 3'b000) begin
      n_fail++; $display("FAIL pixel_0_0 got %b expected 000", px_0_0);
    end
    n_checks++;
    if (px_639_32 !== 3'b100) begin
      n_fail++; $display("FAIL pixel_639_32 got %b expected 100", px_639_32);
    end
    n_checks++;
    if (px_640_32 !== 3'b000) begin
      n_fail++; $display("FAIL pixel_640_32 got %b expected 000", px_640_32);
    end
  endtask

  task automatic test_mid_reset();
    Reset = 1'b0;
    t = 0;
    #1;
    n_checks++;
    if ({VGA_HS, VGA_VS, VGA_RED, VGA_GREEN, VGA_BLUE, No_se} !== 6'b110000) begin
      n_fail++;
      $display("FAIL mid_reset_async got %b expected 110000",
               {VGA_HS, VGA_VS, VGA_RED, VGA_GREEN, VGA_BLUE, No_se});
    end
    for (int i = 0; i < 4; i++) tick();
    Reset = 1'b1;
    for (int i = 0; i < 1700; i++) begin
      tick();
      model(t, e_hs, e_vs, e_rgb, e_nose);
      n_checks++;
      if ({VGA_HS, VGA_VS, VGA_RED, VGA_GREEN, VGA_BLUE, No_se} !== {e_hs, e_vs, e_rgb, e_nose}) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL restart t=%0d got %b expected %b", t,
                   {VGA_HS, VGA_VS, VGA_RED, VGA_GREEN, VGA_BLUE, No_se}, {e_hs, e_vs, e_rgb, e_nose});
      end
    end
  endtask

  task automatic test_random_reset();
    int run_len, hold_len;
    for (int it = 0; it < 6; it++) begin
      run_len  = int'($urandom_range(1, 1700));
      hold_len = int'($urandom_range(1, 4));
      for (int i = 0; i < run_len; i++) begin
        tick();
        model(t, e_hs, e_vs, e_rgb, e_nose);
        n_checks++;
        if ({VGA_HS, VGA_VS, VGA_RED, VGA_GREEN, VGA_BLUE, No_se} !== {e_hs, e_vs, e_rgb, e_nose}) begin
          n_fail++;
          if (n_fail <= 20)
            $display("FAIL random_run it=%0d t=%0d got %b expected %b", it, t,
                     {VGA_HS, VGA_VS, VGA_RED, VGA_GREEN, VGA_BLUE, No_se}, {e_hs, e_vs, e_rgb, e_nose});
        end
      end
      Reset = 1'b0;
      t = 0;
      #1;
      for (int i = 0; i <= hold_len; i++) begin
        n_checks++;
        if ({VGA_HS, VGA_VS, VGA_RED, VGA_GREEN, VGA_BLUE, No_se} !== 6'b110000) begin
          n_fail++;
          $display("FAIL random_reset it=%0d cycle %0d got %b expected 110000", it, i,
                   {VGA_HS, VGA_VS, VGA_RED, VGA_GREEN, VGA_BLUE, No_se});
        end
        if (i < hold_len) tick();
      end
      Reset = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_hsync();
    test_halt();
    test_frame();
    test_pixels();
    test_mid_reset();
    test_random_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
